// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
// Arbitrates the single external memory port between instruction fetch and data
// load/store traffic, one request/ack bus transaction at a time, with ack timeout.
module memory_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_read_addr,
    input  logic [31:0] d_write_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_read,
    output logic        bus_write,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        err,
    output logic        busy,
    output logic [2:0]  dbg_state_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_data_q, last_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    logic data_req;
    logic grant_fetch;
    logic timed_out;

    assign data_req    = d_read | d_write;
    // On a tie, the side that did not win last time goes first.
    assign grant_fetch = if_req & (~data_req | last_data_q);
    assign timed_out   = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || data_req) begin
                    last_data_d = ~grant_fetch;
                    cnt_d       = '0;
                    if (grant_fetch) begin
                        state_d = FETCH;
                        addr_d  = if_addr;
                    end else if (d_write) begin
                        state_d = DWRITE;
                        addr_d  = d_write_addr;
                        wdata_d = d_wdata;
                    end else begin
                        state_d = DREAD;
                        addr_d  = d_read_addr;
                    end
                end
            end
            FETCH, DREAD, DWRITE: begin
                if (bus_ack || timed_out) begin
                    // Ack beats a coincident timeout; a write or an abort returns zero.
                    state_d = RESP;
                    err_d   = ~bus_ack;
                    if (state_q == FETCH) begin
                        if_rdata_d = bus_ack ? bus_rdata : 32'd0;
                    end else begin
                        d_rdata_d = (bus_ack && state_q == DREAD) ? bus_rdata : 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_read    = (state_q == FETCH) || (state_q == DREAD);
        bus_write   = (state_q == DWRITE);
        bus_addr    = addr_q;
        bus_wdata   = wdata_q;
        if_done     = (state_q == RESP) && !last_data_q;
        d_done      = (state_q == RESP) && last_data_q;
        err         = (state_q == RESP) && err_q;
        busy        = (state_q != IDLE);
        if_rdata    = if_rdata_q;
        d_rdata     = d_rdata_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// Randomized transaction-level bench for memory_arbiter: the bench plays both
// requesters and the memory, and predicts grants, bus fields and responses.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_read_addr;
  logic [31:0] d_write_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        err;
  logic        busy;
  logic [2:0]  dbg_state;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_read_addr(d_read_addr),
    .d_write_addr(d_write_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read(bus_read), .bus_write(bus_write),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err(err), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // requester-side bookkeeping
  bit          f_pend, d_pend, d_wr, d_both;
  logic [31:0] f_addr_v, d_raddr_v, d_waddr_v, d_wdata_v;
  // reference model
  bit          m_last_data;
  logic [31:0] m_if_rdata, m_d_rdata;

  task automatic drive_reqs();
    if_req       = f_pend;
    if_addr      = f_addr_v;
    d_read       = d_pend && (!d_wr || d_both);
    d_write      = d_pend && d_wr;
    d_read_addr  = d_raddr_v;
    d_write_addr = d_waddr_v;
    d_wdata      = d_wdata_v;
  endtask

  task automatic model_reset();
    m_last_data = 1'b1;
    m_if_rdata  = '0;
    m_d_rdata   = '0;
  endtask

  // Called at the falling edge of an IDLE cycle with pending requests set up.
  // k: bus cycle on which memory acks (k > TO means never).
  task automatic do_txn(input int k, input logic [31:0] rd);
    bit          win_f, ewr, eerr;
    logic [31:0] ea, ew, erd;
    drive_reqs();
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'({if_done, d_done, err}), 32'd0);
    chk("hold_if_rdata", if_rdata, m_if_rdata);
    chk("hold_d_rdata", d_rdata, m_d_rdata);
    win_f       = f_pend && (!d_pend || m_last_data);
    m_last_data = !win_f;
    ewr = !win_f && d_wr;
    ea  = win_f ? f_addr_v : (d_wr ? d_waddr_v : d_raddr_v);
    ew  = d_wdata_v;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      chk("bus_read", 32'(bus_read), 32'(!ewr));
      chk("bus_write", 32'(bus_write), 32'(ewr));
      chk("bus_addr", bus_addr, ea);
      if (ewr) chk("bus_wdata", bus_wdata, ew);
      chk("bus_busy", 32'(busy), 32'd1);
      chk("bus_nodone", 32'({if_done, d_done, err}), 32'd0);
      if (win_f) begin
        if_addr = $urandom;
      end else begin
        d_read_addr  = $urandom;
        d_write_addr = $urandom;
        d_wdata      = $urandom;
      end
      bus_ack   = (c == k);
      bus_rdata = (c == k) ? rd : $urandom;
      if (c == k) break;
    end
    eerr = (k > TO);
    erd  = (eerr || ewr) ? 32'd0 : rd;
    @(negedge clk);
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    chk("resp_if_done", 32'(if_done), 32'(win_f));
    chk("resp_d_done", 32'(d_done), 32'(!win_f));
    chk("resp_err", 32'(err), 32'(eerr));
    chk("resp_strobes", 32'({bus_read, bus_write}), 32'd0);
    chk("resp_busy", 32'(busy), 32'd1);
    if (win_f) begin
      chk("resp_if_rdata", if_rdata, erd);
      m_if_rdata = erd;
      f_pend = 1'b0;
    end else begin
      chk("resp_d_rdata", d_rdata, erd);
      m_d_rdata = erd;
      d_pend = 1'b0;
    end
    drive_reqs();
    @(negedge clk);
  endtask

  task automatic new_fetch(input logic [31:0] a);
    f_pend = 1'b1;
    f_addr_v = a;
  endtask

  task automatic new_data(input bit wr, input bit both, input logic [31:0] ra,
                          input logic [31:0] wa, input logic [31:0] wd);
    d_pend = 1'b1;
    d_wr = wr;
    d_both = both;
    d_raddr_v = ra;
    d_waddr_v = wa;
    d_wdata_v = wd;
  endtask

  initial begin
    rst = 1'b1;
    f_pend = 0; d_pend = 0; d_wr = 0; d_both = 0;
    f_addr_v = 0; d_raddr_v = 0; d_waddr_v = 0; d_wdata_v = 0;
    model_reset();
    drive_reqs();
    bus_ack = 1'b0;
    bus_rdata = '0;
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_strobes", 32'({bus_read, bus_write}), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_done_err", 32'({if_done, d_done, err}), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single fetch, ack one cycle after the strobe rises
    new_fetch(32'h100);
    do_txn(2, 32'h0050_0093);
    // store acked on its third strobe cycle
    new_data(1'b1, 1'b0, 32'h0, 32'h2004, 32'hDEAD_BEEF);
    do_txn(3, 32'hCAFE_0000);
    // load that never gets an ack
    new_data(1'b0, 1'b0, 32'h3000, 32'h0, 32'h0);
    do_txn(TO + 1, 32'h5555_5555);
    // ack on the very cycle the timeout would fire
    new_data(1'b0, 1'b0, 32'h3004, 32'h0, 32'h0);
    do_txn(TO, 32'h1234);
    // illegal read+write: only the write is serviced
    new_data(1'b1, 1'b1, 32'h4000, 32'h4004, 32'h0BAD_F00D);
    do_txn(1, 32'h7777_7777);
    // sustained contention: both sides re-request right after each completion
    for (int i = 0; i < 4; i++) begin
      if (!f_pend) new_fetch(32'h1000 + 32'(i * 4));
      if (!d_pend) new_data(1'b0, 1'b0, 32'h8000 + 32'(i * 4), 32'h0, 32'h0);
      do_txn(int'($urandom_range(1, 2)), $urandom);
    end

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if (!f_pend && $urandom_range(0, 1) == 1) new_fetch($urandom);
      if (!d_pend && $urandom_range(0, 1) == 1)
        new_data(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 $urandom, $urandom, $urandom);
      if (!f_pend && !d_pend) new_fetch($urandom);
      do_txn(int'($urandom_range(1, TO + 1)), $urandom);
    end
    while (f_pend || d_pend) do_txn(int'($urandom_range(1, TO)), $urandom);

    // reset in the middle of a fetch
    new_fetch(32'hA000);
    drive_reqs();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("preRst_read", 32'(bus_read), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midRst_read", 32'(bus_read), 32'd0);
    chk("midRst_busy", 32'(busy), 32'd0);
    chk("midRst_done", 32'(if_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // after reset a tie must go to fetch first
    new_data(1'b0, 1'b0, 32'hB000, 32'h0, 32'h0);
    do_txn(2, 32'h1111_2222);
    do_txn(1, 32'h3333_4444);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the core's single external memory port between instruction fetch and data load/store traffic. Data addresses come from the ALU's read_address/write_address outputs. The block arbitrates fairly when both sides request, and sequences one bus transaction at a time through a request/ack handshake. It returns read data and a one-cycle done pulse to the winning requester, and aborts transactions that never receive an ack.

## Interface
- TIMEOUT, 255: max cycles a bus transaction waits for bus_ack before abort (≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word, valid while if_done=1
- if_done  out  1  one-cycle fetch completion pulse
- d_read  in  1  data load request, level, held until d_done
- d_write  in  1  data store request, level, held until d_done
- d_read_addr  in  32  load address (ALU read_address)
- d_write_addr  in  32  store address (ALU write_address)
- d_wdata  in  32  store data (ALU result on stores)
- d_rdata  out  32  loaded word, valid while d_done=1
- d_done  out  1  one-cycle data completion pulse
- bus_addr  out  32  memory address
- bus_wdata  out  32  memory write data
- bus_read  out  1  memory read strobe, held until ack
- bus_write  out  1  memory write strobe, held until ack
- bus_rdata  in  32  memory read data, sampled on ack
- bus_ack  in  1  memory completion, one cycle
- err  out  1  one-cycle pulse with a done when that transaction timed out
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, FETCH, DREAD, DWRITE, RESP.
- IDLE: data request = d_read|d_write.
  - Only one side requesting: grant it.
  - Both requesting: grant the side not granted last (last_grant register).
  - Neither requesting: stay in IDLE.
- Data grant with d_write=1 goes to DWRITE, else DREAD. d_read&d_write together is illegal; the block services the write only.
- On grant, register the address and data:
  - FETCH: bus_addr=if_addr, bus_read=1.
  - DREAD: bus_addr=d_read_addr, bus_read=1.
  - DWRITE: bus_addr=d_write_addr, bus_wdata=d_wdata, bus_write=1.
- Update last_grant on grant.
- Address and data are captured at grant. Requester input changes afterwards are ignored.
- Bus states hold strobe, address and data stable until bus_ack=1 or timeout.
- On ack:
  - FETCH: capture bus_rdata into if_rdata.
  - DREAD: capture bus_rdata into d_rdata.
  - DWRITE: leave d_rdata at 0.
  - Go to RESP.
- Timeout: wait counter clears on bus-state entry and increments each cycle without ack. When it reaches TIMEOUT-1 without ack (TIMEOUT bus cycles total), go to RESP with err=1 and captured rdata=0.
- Ack in the same cycle as timeout: ack wins, err=0.
- RESP:
  - Strobes low.
  - The granted side's done=1 for exactly one cycle, with rdata and err valid.
  - Next state is IDLE.
  - The RESP cycle prevents re-granting a request the requester has not yet dropped.
- Requester dropping its req mid-transaction does not abort; done still pulses.
- if_rdata/d_rdata hold their value until the next capture on their side. done and err are low outside RESP.

## Timing
- Reset (async, immediate): state IDLE, all outputs 0, counter 0, last_grant=DATA (fetch wins first tie).
- Reset mid-transaction: strobes drop immediately; no done is issued.
- Cycle 0: IDLE sees request.
- Cycle 1: strobe high (registered outputs).
- Earliest ack: cycle 1, then done at cycle 2, IDLE at cycle 3.
- Minimum turnaround is 3 cycles; the next grant can drive the bus at cycle 4.
- Ack at bus cycle k (k≥1): done at cycle k+1.
- Timeout: strobe high cycles 1..TIMEOUT, done+err at cycle TIMEOUT+1.
- bus_ack outside a bus state is ignored.
- Counter width ≥ $clog2(TIMEOUT); no wrap-around inside a transaction.

## Test plan
- Single fetch: if_req=1, if_addr=0x100, memory acks 1 cycle after strobe with 0x00500093 → bus_read high at cycle 1 with bus_addr=0x100; if_done=1 at cycle 3 with if_rdata=0x00500093; err=0; busy low at cycle 4.
- Store: d_write=1, d_write_addr=0x2004, d_wdata=0xDEADBEEF, ack on 3rd strobe cycle → bus_write=1 with addr/data stable for 3 cycles; d_done pulses once; d_rdata=0.
- Contention: if_req and d_read both held continuously after reset, each dropped one cycle after its done → grant order FETCH, DREAD, FETCH, DREAD; never two consecutive grants to one side.
- Timeout: TIMEOUT=4, d_read to 0x3000, no ack → bus_read high exactly 4 cycles; then d_done=1, err=1, d_rdata=0; then IDLE.
- Ack coincident with timeout (TIMEOUT=4, ack on 4th cycle, bus_rdata=0x1234) → err=0, d_rdata=0x1234.
- Reset mid-op: assert rst on bus cycle 2 of a fetch → bus_read, busy and if_done are 0 in that same cycle. After release, a tie is granted to fetch first.
